jtag_tap_master: RTL and testbench

//  Host-side JTAG TAP initiator: the driving end of the virtual-JTAG debug path (IR/DR scans into a TAP).

---
 rtl/jtag_tap_master.sv | 196 +++++++++++++++++++
 tb/tb_jtag_tap_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_master.sv
// Host-side JTAG TAP initiator: walks the 1149.1 TAP through one IR/DR scan per command
// and returns the captured tdo word. tck is derived from clk by CLK_DIV.
module jtag_tap_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  input  logic               tap_rst_req,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    TLR_SEQ,
    IDLE,
    PRE,
    SHIFT,
    POST,
    RESP
  } state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   bit_cnt, bit_nxt;
  logic [LEN_W-1:0]   len_q, eff_len;
  logic [MAX_LEN-1:0] data_q, rsp_q, data_shift;
  logic               is_ir_q;
  logic [DIV_W-1:0]   div_cnt;
  logic               hi;
  logic               tck_q, tms_q, tdi_q;
  logic               tms_nxt, tdi_nxt;
  logic               running, div_last, bit_end, sample, accept, rst_tap;

  assign running  = state inside {TLR_SEQ, PRE, SHIFT, POST};
  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_end  = running && hi && div_last;
  // tdo is captured one clk before tck falls, clear of the TAP's falling-edge update
  assign sample   = (state == SHIFT) && hi && (div_cnt == DIV_W'(CLK_DIV - 2));
  assign accept   = (state == IDLE) && cmd_valid && !tap_rst_req;
  assign rst_tap  = (state == IDLE) && tap_rst_req;

  always_comb begin
    eff_len = cmd_len;
    if (cmd_len == '0)
      eff_len = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_LEN))
      eff_len = LEN_W'(MAX_LEN);
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    case (state)
      IDLE: begin
        if (tap_rst_req) begin
          state_nxt = TLR_SEQ;
          bit_nxt   = '0;
        end else if (cmd_valid) begin
          state_nxt = PRE;
          bit_nxt   = '0;
        end
      end
      TLR_SEQ: if (bit_end) begin
        if (bit_cnt == LEN_W'(5)) begin
          state_nxt = IDLE;
          bit_nxt   = '0;
        end else
          bit_nxt = bit_cnt + LEN_W'(1);
      end
      PRE: if (bit_end) begin
        if (bit_cnt == (is_ir_q ? LEN_W'(3) : LEN_W'(2))) begin
          state_nxt = SHIFT;
          bit_nxt   = '0;
        end else
          bit_nxt = bit_cnt + LEN_W'(1);
      end
      SHIFT: if (bit_end) begin
        if (bit_cnt == len_q - LEN_W'(1)) begin
          state_nxt = POST;
          bit_nxt   = '0;
        end else
          bit_nxt = bit_cnt + LEN_W'(1);
      end
      POST: if (bit_end) begin
        if (bit_cnt == LEN_W'(1)) begin
          state_nxt = RESP;
          bit_nxt   = '0;
        end else
          bit_nxt = bit_cnt + LEN_W'(1);
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: begin
        state_nxt = TLR_SEQ;
        bit_nxt   = '0;
      end
    endcase
  end

  // tms/tdi for the bit that starts at the next edge; held when the walk stops
  always_comb begin
    tms_nxt    = tms_q;
    tdi_nxt    = tdi_q;
    data_shift = data_q >> bit_nxt;
    case (state_nxt)
      TLR_SEQ: begin
        tms_nxt = (bit_nxt < LEN_W'(5));
        tdi_nxt = 1'b0;
      end
      PRE: begin
        tms_nxt = is_ir_q ? (bit_nxt < LEN_W'(2)) : (bit_nxt == '0);
        tdi_nxt = 1'b0;
      end
      SHIFT: begin
        tms_nxt = (bit_nxt == len_q - LEN_W'(1));
        tdi_nxt = data_shift[0];
      end
      POST: begin
        tms_nxt = (bit_nxt == '0);
        tdi_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= TLR_SEQ;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      hi      <= 1'b0;
      div_cnt <= '0;
      rsp_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      is_ir_q <= 1'b0;
    end else begin
      if (accept) begin
        len_q   <= eff_len;
        data_q  <= cmd_data;
        is_ir_q <= cmd_is_ir;
        rsp_q   <= '0;
      end
      if (accept || rst_tap) begin
        hi      <= 1'b0;
        div_cnt <= '0;
        tck_q   <= 1'b0;
      end else if (running) begin
        if (div_last) begin
          div_cnt <= '0;
          hi      <= ~hi;
          tck_q   <= ~hi;
        end else
          div_cnt <= div_cnt + DIV_W'(1);
      end
      if (accept || rst_tap || bit_end) begin
        tms_q <= tms_nxt;
        tdi_q <= tdi_nxt;
      end
      if (sample)
        rsp_q <= rsp_q | (MAX_LEN'(tdo) << bit_cnt);
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master: TLR walk, DR/IR scans, response hold,
// mid-scan reset, length clamping and tap_rst_req priority.
module tb_jtag_tap_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_is_ir;
  logic [6:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        tap_rst_req;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic        busy, tck, tms, tdi, tdo;

  logic        tdo_mode = 1'b0;
  logic        tdo_m = 1'b0;
  int          tck_cnt = 0;
  logic [127:0] tms_rec = '0;
  logic [127:0] tdi_rec = '0;

  int n_cmp = 0;
  int n_err = 0;

  jtag_tap_master #(.CLK_DIV(4), .MAX_LEN(64), .LEN_W(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_ir(cmd_is_ir),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .tap_rst_req(tap_rst_req),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // TAP-side observer: records tms/tdi at each tck rise; loopback returns that bit
  always @(posedge tck) begin
    tck_cnt <= tck_cnt + 1;
    tms_rec <= {tms_rec[126:0], tms};
    tdi_rec <= {tdi_rec[126:0], tdi};
    tdo_m   <= tdi;
  end
  assign tdo = tdo_mode ? 1'b1 : tdo_m;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic ir, input logic [6:0] len, input logic [63:0] data,
                          input logic pulse, output int lat, output int ntck);
    int c0;
    cmd_is_ir = ir;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    c0 = tck_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = '1;
    cmd_len   = 7'd3;
    cmd_is_ir = ~ir;
    lat = 0;
    while (!rsp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
      tap_rst_req = pulse && (lat == 10);
    end
    tap_rst_req = 1'b0;
    ntck = tck_cnt - c0;
  endtask

  task automatic release_resp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic watch_tlr(input string tag);
    int  c0;
    logic saw;
    c0  = tck_cnt;
    saw = 1'b0;
    repeat (47) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    chk({tag, "_ready_c47"}, cmd_ready, 1'b0);
    @(negedge clk);
    chk({tag, "_ready_c48"}, cmd_ready, 1'b1);
    chk({tag, "_tck_count"}, tck_cnt - c0, 6);
    chk({tag, "_tms_seq"}, tms_rec[5:0], 6'b111110);
    chk({tag, "_no_rsp"}, saw, 1'b0);
  endtask

  int lat, ntck;
  logic [127:0] exp_tms;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_is_ir = 1'b0; cmd_len = '0;
    cmd_data = '0; tap_rst_req = 1'b0; rsp_ready = 1'b0;

    // 1: reset values and TLR walk
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 1'b0);
    chk("rst_tms", tms, 1'b1);
    chk("rst_tdi", tdi, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_rspv", rsp_valid, 1'b0);
    chk("rst_rspd", rsp_data, 64'h0);
    chk("rst_busy", busy, 1'b1);
    reset_n = 1'b1;
    watch_tlr("tlr1");
    chk("idle_tck", tck, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // 2: DR scan, loopback tdo
    tdo_mode = 1'b0;
    run_scan(1'b0, 7'd8, 64'hA5, 1'b0, lat, ntck);
    chk("dr_latency", lat, 104);
    chk("dr_tck", ntck, 13);
    chk("dr_tms", tms_rec[12:0], 13'h1006);
    chk("dr_tdi", tdi_rec[12:0], 13'h0294);
    chk("dr_rsp", rsp_data, 64'hA5);
    chk("dr_ready_in_resp", cmd_ready, 1'b0);
    release_resp();
    chk("dr_rspv_drop", rsp_valid, 1'b0);
    chk("dr_ready_back", cmd_ready, 1'b1);

    // 3: IR scan, tdo tied high
    tdo_mode = 1'b1;
    run_scan(1'b1, 7'd10, 64'h002, 1'b0, lat, ntck);
    chk("ir_latency", lat, 128);
    chk("ir_tck", ntck, 16);
    chk("ir_tms", tms_rec[15:0], 16'hC006);
    chk("ir_rsp", rsp_data, 64'h3FF);

    // 4: response held under backpressure
    repeat (20) @(negedge clk);
    chk("hold_rspv", rsp_valid, 1'b1);
    chk("hold_rspd", rsp_data, 64'h3FF);
    chk("hold_ready", cmd_ready, 1'b0);
    chk("hold_tck", tck, 1'b0);
    release_resp();
    chk("hold_ready_back", cmd_ready, 1'b1);
    chk("hold_busy", busy, 1'b0);

    // 5: reset during SHIFT bit 3
    tdo_mode = 1'b0;
    cmd_is_ir = 1'b0; cmd_len = 7'd8; cmd_data = 64'hFF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (52) @(negedge clk);
    chk("mid_tck_high", tck, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_tck", tck, 1'b0);
    chk("mid_rst_tms", tms, 1'b1);
    chk("mid_rst_rspv", rsp_valid, 1'b0);
    chk("mid_rst_rspd", rsp_data, 64'h0);
    chk("mid_rst_busy", busy, 1'b1);
    watch_tlr("tlr2");

    // 6a: zero length -> 1 bit; tap_rst_req mid-scan ignored
    run_scan(1'b0, 7'd0, 64'h1, 1'b1, lat, ntck);
    chk("len0_latency", lat, 48);
    chk("len0_tck", ntck, 6);
    chk("len0_tms", tms_rec[5:0], 6'b100110);
    chk("len0_rsp", rsp_data, 64'h1);
    release_resp();

    // 6b: oversize length clamps to 64
    run_scan(1'b0, 7'd100, 64'hDEADBEEF01234567, 1'b0, lat, ntck);
    exp_tms = 128'd6 | (128'd1 << 68);
    chk("len100_latency", lat, 552);
    chk("len100_tck", ntck, 69);
    chk("len100_tms", tms_rec[68:0], exp_tms);
    chk("len100_rsp", rsp_data, 64'hDEADBEEF01234567);
    release_resp();

    // 6c: tap_rst_req beats cmd_valid
    cmd_is_ir = 1'b0; cmd_len = 7'd8; cmd_data = 64'h5A;
    cmd_valid = 1'b1; tap_rst_req = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; tap_rst_req = 1'b0;
    chk("prio_ready", cmd_ready, 1'b0);
    chk("prio_busy", busy, 1'b1);
    chk("prio_tms", tms, 1'b1);
    watch_tlr("tlr3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
